mem_port_arbiter: RTL and testbench

Shares one external memory port between the instruction-fetch requester (IF) and the data-memory requester (MEM), and produces the `Inst_Stall` and `M_Stall_Controller` stall inputs of the hazard unit. Each granted request is latched and run as a single bus transaction. The read data or write completion is returned to the owner with a one-cycle ready pulse. It sits between the pipeline's IF/MEM stages and the single-ported memory bus.

---
 rtl/mem_port_arbiter_if.sv | 58 +++++
 rtl/mem_port_arbiter.sv | 124 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if
//   Bundles the fetch requester (I_*), data requester (D_*), the stall
//   outputs to the hazard unit and the single memory bus (Bus_*) that
//   mem_port_arbiter shares between them.
//   Modports:
//     slave  - the arbiter: takes requests and bus read data/ack, drives
//              ready pulses, read data, stalls and the bus command.
//     master - the environment: pipeline requesters plus memory.
interface mem_port_arbiter_if #(
   parameter int ADDR_W = 30,
   parameter int DATA_W = 32
);
   localparam int BE_W = DATA_W / 8;

   // fetch side
   logic              I_Req;
   logic [ADDR_W-1:0] I_Addr;
   logic [DATA_W-1:0] I_RData;
   logic              I_Ready;
   logic              Inst_Stall;

   // data side
   logic              D_Req;
   logic              D_Write;
   logic [ADDR_W-1:0] D_Addr;
   logic [DATA_W-1:0] D_WData;
   logic [BE_W-1:0]   D_BE;
   logic [DATA_W-1:0] D_RData;
   logic              D_Ready;
   logic              M_Stall_Controller;

   // memory bus
   logic              Bus_Req;
   logic              Bus_Write;
   logic [ADDR_W-1:0] Bus_Addr;
   logic [DATA_W-1:0] Bus_WData;
   logic [BE_W-1:0]   Bus_BE;
   logic [DATA_W-1:0] Bus_RData;
   logic              Bus_Ack;

   modport slave (
      input  I_Req, I_Addr,
      output I_RData, I_Ready, Inst_Stall,
      input  D_Req, D_Write, D_Addr, D_WData, D_BE,
      output D_RData, D_Ready, M_Stall_Controller,
      output Bus_Req, Bus_Write, Bus_Addr, Bus_WData, Bus_BE,
      input  Bus_RData, Bus_Ack
   );

   modport master (
      output I_Req, I_Addr,
      input  I_RData, I_Ready, Inst_Stall,
      output D_Req, D_Write, D_Addr, D_WData, D_BE,
      input  D_RData, D_Ready, M_Stall_Controller,
      input  Bus_Req, Bus_Write, Bus_Addr, Bus_WData, Bus_BE,
      output Bus_RData, Bus_Ack
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one external memory port between instruction fetch (I) and data
//   memory (D). A granted request is latched into the bus registers and run
//   as one transaction (IDLE -> BUSY -> RESP -> IDLE); the result is returned
//   to the owner with a one-cycle ready pulse, unless the owner withdrew its
//   request before the ack.
//   Ports:
//     clock - rising-edge clock
//     reset - asynchronous, active-high
//     mp    - mem_port_arbiter_if.slave: requesters, stalls, memory bus
//   Build option:
//     MEM_ARB_RR_EN - defined: round-robin on ties (last-owner register,
//                     resets to I so D wins the first tie).
//                     undefined: D always beats I on ties.
module mem_port_arbiter #(
   parameter int ADDR_W = 30,
   parameter int DATA_W = 32
) (
   input logic               clock,
   input logic               reset,
   mem_port_arbiter_if.slave mp
);
   localparam int BE_W = DATA_W / 8;

   typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, RESP = 2'd2} state_t;

   state_t            state, state_nxt;
   logic              req_any;
   logic              grant_d;      // 1: D wins this arbitration
   logic              owner_d;      // 1: current transaction belongs to D
   logic              bus_write_q;
   logic [ADDR_W-1:0] bus_addr_q;
   logic [DATA_W-1:0] bus_wdata_q;
   logic [BE_W-1:0]   bus_be_q;
   logic [DATA_W-1:0] rdata_q;
   logic              i_ready_q;
   logic              d_ready_q;

   assign req_any = mp.I_Req | mp.D_Req;

`ifdef MEM_ARB_RR_EN
   logic last_d;  // owner of the previous grant

   // On a tie, serve whoever did not get the previous grant.
   assign grant_d = mp.D_Req & (~mp.I_Req | ~last_d);

   always_ff @(posedge clock or posedge reset) begin
      if (reset)
         last_d <= 1'b0;
      else if (state == IDLE && req_any)
         last_d <= grant_d;
   end
`else
   assign grant_d = mp.D_Req;
`endif

   // state register
   always_ff @(posedge clock or posedge reset) begin
      if (reset)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   // next state
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (req_any) state_nxt = BUSY;
         BUSY:    if (mp.Bus_Ack) state_nxt = RESP;
         RESP:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Bus registers load only in IDLE, so they hold steady for all of BUSY.
   // The ready pulse is decided at the ack edge: an owner that has dropped
   // its request by then gets no pulse and the result is discarded.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         owner_d     <= 1'b0;
         bus_write_q <= 1'b0;
         bus_addr_q  <= '0;
         bus_wdata_q <= '0;
         bus_be_q    <= '1;
         rdata_q     <= '0;
         i_ready_q   <= 1'b0;
         d_ready_q   <= 1'b0;
      end else begin
         i_ready_q <= 1'b0;
         d_ready_q <= 1'b0;
         if (state == IDLE && req_any) begin
            owner_d <= grant_d;
            if (grant_d) begin
               bus_write_q <= mp.D_Write;
               bus_addr_q  <= mp.D_Addr;
               bus_wdata_q <= mp.D_WData;
               bus_be_q    <= mp.D_Write ? mp.D_BE : '1;
            end else begin
               bus_write_q <= 1'b0;
               bus_addr_q  <= mp.I_Addr;
               bus_be_q    <= '1;
            end
         end
         if (state == BUSY && mp.Bus_Ack) begin
            rdata_q   <= mp.Bus_RData;
            i_ready_q <= ~owner_d & mp.I_Req;
            d_ready_q <= owner_d & mp.D_Req;
         end
      end
   end

   assign mp.Bus_Req            = (state == BUSY);
   assign mp.Bus_Write          = bus_write_q;
   assign mp.Bus_Addr           = bus_addr_q;
   assign mp.Bus_WData          = bus_wdata_q;
   assign mp.Bus_BE             = bus_be_q;
   assign mp.I_RData            = rdata_q;
   assign mp.D_RData            = rdata_q;
   assign mp.I_Ready            = i_ready_q;
   assign mp.D_Ready            = d_ready_q;
   assign mp.Inst_Stall         = mp.I_Req & ~i_ready_q;
   assign mp.M_Stall_Controller = mp.D_Req & ~d_ready_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
//   Randomized requester/memory environment for mem_port_arbiter. The driver
//   decides each grant from the arbitration rules and queues the expected bus
//   command and response; a memory responder acks with delay and returns a
//   known function of the address; a monitor checks every bus start, the bus
//   hold, every ready cycle and the stall outputs against those queues.
module tb_mem_port_arbiter;
   localparam int AW = 30;
   localparam int DW = 32;

   typedef struct {
      bit          wr;
      logic [29:0] addr;
      logic [31:0] wdata;
      logic [3:0]  be;
   } bus_t;

   typedef struct {
      bit          d;     // owner is D
      bit          rd;    // data is meaningful
      bit          wd;    // owner withdraws: no pulse expected
      logic [31:0] data;
   } rsp_t;

   logic clock = 1'b0;
   logic reset = 1'b1;
   always #5 clock = ~clock;

   mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) mp ();
   mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
      .clock(clock),
      .reset(reset),
      .mp   (mp)
   );

   int   cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   bus_t bus_q[$];
   rsp_t rsp_q[$];
   int   due_q[$];
   int   vectors = 0;
   int   miscompares = 0;

   function automatic logic [31:0] fdata(logic [29:0] a);
      return {a, 2'b01} ^ 32'hA5C3_0F96;
   endfunction

   task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
      end
   endtask

   task automatic chk_reset_vals(string tag);
      chk({tag, "_bus_req"},   mp.Bus_Req,   0);
      chk({tag, "_bus_write"}, mp.Bus_Write, 0);
      chk({tag, "_bus_addr"},  mp.Bus_Addr,  0);
      chk({tag, "_bus_wdata"}, mp.Bus_WData, 0);
      chk({tag, "_bus_be"},    mp.Bus_BE,    4'hF);
      chk({tag, "_i_ready"},   mp.I_Ready,   0);
      chk({tag, "_d_ready"},   mp.D_Ready,   0);
      chk({tag, "_rdata"},     mp.I_RData,   0);
   endtask

   // ---------------- driver + reference model ----------------
   bit          i_hold, d_hold, dwr, last_d;
   logic [29:0] ia, da;
   logic [31:0] dwd;
   logic [3:0]  dbe;

   task automatic apply();
      mp.I_Req   = i_hold;
      mp.I_Addr  = ia;
      mp.D_Req   = d_hold;
      mp.D_Write = dwr;
      mp.D_Addr  = da;
      mp.D_WData = dwd;
      mp.D_BE    = dbe;
   endtask

   initial begin
      bit   win_d, wd;
      int   t;
      bus_t b;
      rsp_t r;
      i_hold = 0; d_hold = 0; dwr = 0; last_d = 0;
      ia = '0; da = '0; dwd = '0; dbe = '0;
      apply();
      repeat (2) @(posedge clock);
      #2;
      chk_reset_vals("por");
      #1 reset = 1'b0;
      @(posedge clock); #1;
      for (int rnd = 0; rnd < 300; rnd++) begin
         if (rnd == 150) begin
            // reset in the middle of a fetch transaction
            i_hold = 1; ia = 30'($urandom); d_hold = 0;
            apply();
            b = '{wr: 0, addr: ia, wdata: '0, be: 4'hF};
            bus_q.push_back(b);
            @(posedge clock); #1;
            chk("rst_busy_entered", mp.Bus_Req, 1);
            #2 reset = 1'b1;
            #1 chk_reset_vals("mid");
            i_hold = 0; apply();
            bus_q.delete(); rsp_q.delete(); due_q.delete();
            last_d = 0;
            @(posedge clock); #3 reset = 1'b0;
            @(posedge clock); #1;
            continue;
         end
         // held losers keep their request; others may raise a new one
         if (!i_hold && $urandom_range(0, 9) < 6) begin
            i_hold = 1; ia = 30'($urandom);
         end
         if (!d_hold && $urandom_range(0, 9) < 6) begin
            d_hold = 1; da = 30'($urandom); dwr = 1'($urandom);
            dwd = $urandom; dbe = 4'($urandom);
         end
         apply();
         if (!i_hold && !d_hold) begin
            @(posedge clock); #1;
            continue;
         end
`ifdef MEM_ARB_RR_EN
         win_d = (i_hold && d_hold) ? !last_d : d_hold;
`else
         win_d = d_hold;
`endif
         last_d = win_d;
         wd = ($urandom_range(0, 9) == 0);
         if (win_d) begin
            b = '{wr: dwr, addr: da, wdata: dwd, be: dwr ? dbe : 4'hF};
            r = '{d: 1, rd: !dwr, wd: wd, data: fdata(da)};
         end else begin
            b = '{wr: 0, addr: ia, wdata: '0, be: 4'hF};
            r = '{d: 0, rd: 1, wd: wd, data: fdata(ia)};
         end
         bus_q.push_back(b);
         rsp_q.push_back(r);
         @(posedge clock); #1;
         chk("bus_req_start", mp.Bus_Req, 1);
         if (wd) begin
            if (win_d) d_hold = 0; else i_hold = 0;
            apply();
         end
         t = 0;
         while (mp.Bus_Req === 1'b1 && t < 40) begin
            @(posedge clock); #1;
            t++;
         end
         chk("txn_done", mp.Bus_Req, 0);
         // now in the response cycle; the winner is released next cycle
         if (win_d) d_hold = 0; else i_hold = 0;
         @(posedge clock); #1;
      end
      i_hold = 0; d_hold = 0; apply();
      repeat (4) @(posedge clock);
      #1;
      chk("rsp_drained", rsp_q.size(), 0);
      chk("bus_drained", bus_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   // ---------------- memory responder ----------------
   initial begin
      bit acked;
      int cnt;
      acked = 0; cnt = -1;
      mp.Bus_Ack = 1'b0; mp.Bus_RData = '0;
      forever begin
         @(posedge clock); #1;
         mp.Bus_Ack   = 1'b0;
         mp.Bus_RData = $urandom;
         if (reset) begin
            acked = 0; cnt = -1;
            continue;
         end
         if (mp.Bus_Req && !acked) begin
            if (cnt < 0) cnt = $urandom_range(0, 4);
            if (cnt == 0) begin
               mp.Bus_Ack   = 1'b1;
               mp.Bus_RData = fdata(mp.Bus_Addr);
               acked = 1;
               due_q.push_back(cyc + 1);
            end else begin
               cnt--;
            end
         end else if (!mp.Bus_Req) begin
            acked = 0; cnt = -1;
            // stray acks outside BUSY must be ignored
            if ($urandom_range(0, 4) == 0) mp.Bus_Ack = 1'b1;
         end
      end
   end

   // ---------------- monitor ----------------
   initial begin
      bus_t cur;
      rsp_t r;
      bit   prev;
      prev = 0;
      cur = '{wr: 0, addr: '0, wdata: '0, be: '0};
      forever begin
         @(negedge clock);
         if (reset) begin
            prev = 0;
            continue;
         end
         if (mp.Bus_Req && !prev) begin
            chk("bus_expected", bus_q.size() > 0, 1);
            if (bus_q.size() > 0) cur = bus_q.pop_front();
         end
         if (mp.Bus_Req) begin
            chk("bus_write", mp.Bus_Write, cur.wr);
            chk("bus_addr",  mp.Bus_Addr,  cur.addr);
            chk("bus_be",    mp.Bus_BE,    cur.be);
            if (cur.wr) chk("bus_wdata", mp.Bus_WData, cur.wdata);
         end
         prev = mp.Bus_Req;
         if (due_q.size() > 0 && due_q[0] == cyc) begin
            void'(due_q.pop_front());
            chk("rsp_expected", rsp_q.size() > 0, 1);
            if (rsp_q.size() > 0) begin
               r = rsp_q.pop_front();
               if (r.wd) begin
                  chk("withdrawn_i_ready", mp.I_Ready, 0);
                  chk("withdrawn_d_ready", mp.D_Ready, 0);
               end else begin
                  chk("i_ready", mp.I_Ready, !r.d);
                  chk("d_ready", mp.D_Ready, r.d);
                  if (r.rd) chk("rdata", r.d ? mp.D_RData : mp.I_RData, r.data);
               end
            end
         end else begin
            chk("no_stray_ready", {mp.I_Ready, mp.D_Ready}, 0);
         end
         chk("inst_stall", mp.Inst_Stall, mp.I_Req & ~mp.I_Ready);
         chk("m_stall", mp.M_Stall_Controller, mp.D_Req & ~mp.D_Ready);
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, %0d miscompares so far", miscompares);
      $fatal(1);
   end
endmodule
